// File: rtl/ripple_carry_adder_4bit.sv
// ripple_carry_adder_4bit: registered ripple-carry adder, one result per accepted input, latency 1.
// Defining RCA_OVERFLOW_EN adds a registered signed-overflow output.
module ripple_carry_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
`ifdef RCA_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             out_valid
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    assign c[0] = Cin;
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = a[i] & b[i] | c[i] & (a[i] ^ b[i]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sum       <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum  <= s;
                Cout <= c[WIDTH];
            end
        end
    end
`ifdef RCA_OVERFLOW_EN
    // signed overflow: carry into the sign bit differs from carry out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow <= 1'b0;
        else if (in_valid) overflow <= c[WIDTH] ^ c[WIDTH-1];
    end
`endif
endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// tb_ripple_carry_adder_4bit: directed scoreboard bench for ripple_carry_adder_4bit.
module tb_ripple_carry_adder_4bit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       Cin = 1'b0;
    logic [3:0] Sum;
    logic       Cout;
    logic       out_valid;
`ifdef RCA_OVERFLOW_EN
    logic       overflow;
`endif
    typedef struct packed {
        logic       ov;
        logic       co;
        logic [3:0] s;
    } exp_t;
    exp_t q[$];
    exp_t held = '0;
    int   passed = 0;
    int   total = 0;

    ripple_carry_adder_4bit #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .Cin(Cin),
        .Sum(Sum), .Cout(Cout),
`ifdef RCA_OVERFLOW_EN
        .overflow(overflow),
`endif
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [4:0] full;
        logic [3:0] low;
        full = {1'b0, x} + {1'b0, y} + {4'b0, ci};
        low  = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b0, ci};
        return '{ov: full[4] ^ low[3], co: full[4], s: full[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_outs(input string tag, input logic v);
        chk({tag, " out_valid"}, {7'b0, out_valid}, {7'b0, v});
        chk({tag, " Sum"}, {4'b0, Sum}, {4'b0, held.s});
        chk({tag, " Cout"}, {7'b0, Cout}, {7'b0, held.co});
`ifdef RCA_OVERFLOW_EN
        chk({tag, " overflow"}, {7'b0, overflow}, {7'b0, held.ov});
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic [3:0] x, input logic [3:0] y, input logic ci);
        in_valid = v;
        a = x;
        b = y;
        Cin = ci;
        if (v) q.push_back(model(x, y, ci));
        @(posedge clk);
        #1;
        if (q.size() > 0) held = q.pop_front();
        chk_outs(tag, v);
    endtask

    initial begin
        in_valid = 1'b1;
        a = 4'hF;
        b = 4'hF;
        Cin = 1'b1;
        #1;
        chk_outs("reset_async", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset_held", 1'b0);
        rst = 1'b0;
        step("post_reset", 1'b1, 4'hF, 4'hF, 1'b1);
        step("basic", 1'b1, 4'h1, 4'h1, 1'b0);
        step("basic_idle", 1'b0, 4'h7, 4'h9, 1'b1);
        step("stream0", 1'b1, 4'h3, 4'h5, 1'b0);
        step("stream1", 1'b1, 4'h5, 4'h1, 1'b1);
        step("stream2", 1'b1, 4'hD, 4'h5, 1'b1);
        step("stream3", 1'b1, 4'h5, 4'h7, 1'b0);
        step("ripple_all", 1'b1, 4'hF, 4'h0, 1'b1);
        step("zero", 1'b1, 4'h0, 4'h0, 1'b0);
        step("neg_ovf", 1'b1, 4'h8, 4'h8, 1'b0);
        step("idle_hold", 1'b0, 4'h0, 4'h0, 1'b0);
        step("pre_midrst", 1'b1, 4'hD, 4'h5, 1'b1);
        in_valid = 1'b1;
        a = 4'h6;
        b = 4'h6;
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        held = '0;
        chk_outs("mid_reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step("after_midrst", 1'b0, 4'h0, 4'h0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
